seq_booth_mult: RTL and testbench

Parametrised sequential radix-2 Booth multiplier with a start/done handshake and runtime signed/unsigned mode. Next generation of the ArithmeticUnit combinational 16-bit signed multiplier: same operand/product naming, generalised to any WIDTH, one Booth step per clock instead of a full array. The ALU integration layer uses it where area matters more than single-cycle latency.

---
 rtl/seq_booth_mult_if.sv | 22 ++
 rtl/seq_booth_mult.sv | 92 +++++++++
 tb/tb_seq_booth_mult.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_booth_mult_if.sv
// Start/done handshake bundle for seq_booth_mult: operands and mode in, status and product out.
interface seq_booth_mult_if #(
   parameter int WIDTH = 16
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     in0;
   logic [WIDTH-1:0]     in1;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   final_prod;

   modport master (
      output start, signed_mode, in0, in1,
      input  busy, done, final_prod
   );

   modport slave (
      input  start, signed_mode, in0, in1,
      output busy, done, final_prod
   );
endinterface

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock on (WIDTH+1)-bit
// extended operands, so the same datapath serves both signed and unsigned mode.
module seq_booth_mult #(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   seq_booth_mult_if.slave   bus
);

   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e               state_q;
   logic [WIDTH+1:0]     acc_q;
   logic [WIDTH:0]       mul_q;
   logic [WIDTH:0]       mcand_q;
   logic                 qm1_q;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   prod_q;

   logic [WIDTH+1:0]     mExt;
   logic [WIDTH+1:0]     sum_d;
   logic [WIDTH+1:0]     acc_d;
   logic [WIDTH:0]       mul_d;
   logic                 qm1_d;
   logic [2*WIDTH-1:0]   prod_d;
   logic                 lastStep;
   logic                 accept;

   // The extra accumulator bit absorbs -M when M is the most negative (WIDTH+1)-bit value.
   always_comb begin
      mExt  = {mcand_q[WIDTH], mcand_q};
      sum_d = acc_q;
      unique case ({mul_q[0], qm1_q})
         2'b01:   sum_d = acc_q + mExt;
         2'b10:   sum_d = acc_q - mExt;
         default: sum_d = acc_q;
      endcase
      acc_d  = {sum_d[WIDTH+1], sum_d[WIDTH+1:1]};
      mul_d  = {sum_d[0], mul_q[WIDTH:1]};
      qm1_d  = mul_q[0];
      prod_d = {acc_d[WIDTH-2:0], mul_d};
   end

   assign lastStep = (cnt_q == CW'(WIDTH));
   assign accept   = (state_q != RUN) && bus.start;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mul_q   <= '0;
         mcand_q <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else if (accept) begin
         mcand_q <= {bus.signed_mode & bus.in0[WIDTH-1], bus.in0};
         mul_q   <= {bus.signed_mode & bus.in1[WIDTH-1], bus.in1};
         acc_q   <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         state_q <= RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               acc_q <= acc_d;
               mul_q <= mul_d;
               qm1_q <= qm1_d;
               cnt_q <= cnt_q + CW'(1);
               if (lastStep) begin
                  prod_q  <= prod_d;
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy       = (state_q == RUN);
   assign bus.done       = (state_q == DONE);
   assign bus.final_prod = prod_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Scoreboard bench for seq_booth_mult: directed WIDTH=16 vectors and handshake cases,
// plus an exhaustive WIDTH=4 sweep in both modes.
module tb_seq_booth_mult;

   logic clk;
   logic rst;
   int   cyc;
   int   compares;
   int   fails;

   typedef struct packed {
      logic [31:0] prod;
      int          startCyc;
   } exp16_t;

   typedef struct packed {
      logic [7:0]  prod;
      int          startCyc;
   } exp4_t;

   typedef struct packed {
      logic        sm;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
   } vec_t;

   localparam int NVEC = 10;
   localparam vec_t VECS [NVEC] = '{
      '{1'b1, 16'h0000, 16'hE9D2, 32'h00000000},
      '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001},
      '{1'b1, 16'h7530, 16'h7530, 32'h35A4E900},
      '{1'b1, 16'hFB2E, 16'h0036, 32'hFFFEFBB4},
      '{1'b1, 16'h8000, 16'h8000, 32'h40000000},
      '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001},
      '{1'b0, 16'h8000, 16'h8000, 32'h40000000},
      '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000},
      '{1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF},
      '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF}
   };

   exp16_t sb16[$];
   exp4_t  sb4[$];

   seq_booth_mult_if #(.WIDTH(16)) bus16 ();
   seq_booth_mult_if #(.WIDTH(4))  bus4 ();

   seq_booth_mult #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
   seq_booth_mult #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      compares++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus16.done) begin
         if (sb16.size() == 0) begin
            compares++;
            fails++;
            $display("[TB] FAIL unexpected_done16: got done=1, expected no pending result (cycle %0d)", cyc);
         end else begin
            exp16_t e;
            e = sb16.pop_front();
            checkOutput("prod16", 64'(bus16.final_prod), 64'(e.prod));
            checkOutput("latency16", 64'(cyc - e.startCyc), 64'd17);
         end
      end
   end

   always @(negedge clk) begin
      if (bus4.done) begin
         if (sb4.size() == 0) begin
            compares++;
            fails++;
            $display("[TB] FAIL unexpected_done4: got done=1, expected no pending result (cycle %0d)", cyc);
         end else begin
            exp4_t e;
            e = sb4.pop_front();
            checkOutput("prod4", 64'(bus4.final_prod), 64'(e.prod));
            checkOutput("latency4", 64'(cyc - e.startCyc), 64'd5);
         end
      end
   end

   task automatic applyStimulus(input logic sm, input logic [15:0] a, input logic [15:0] b,
                                input logic [31:0] expv);
      exp16_t e;
      bus16.start       = 1'b1;
      bus16.signed_mode = sm;
      bus16.in0         = a;
      bus16.in1         = b;
      e.prod            = expv;
      e.startCyc        = cyc + 1;
      sb16.push_back(e);
      @(negedge clk);
      bus16.start = 1'b0;
   endtask

   task automatic applyStimulus4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                                 input logic [7:0] expv);
      exp4_t e;
      bus4.start       = 1'b1;
      bus4.signed_mode = sm;
      bus4.in0         = a;
      bus4.in1         = b;
      e.prod           = expv;
      e.startCyc       = cyc + 1;
      sb4.push_back(e);
      @(negedge clk);
      bus4.start = 1'b0;
   endtask

   task automatic waitDone16(input int bound);
      int n = 0;
      while (!bus16.done && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!bus16.done) checkOutput("timeout_done16", 64'd0, 64'd1);
   endtask

   task automatic waitDone4(input int bound);
      int n = 0;
      while (!bus4.done && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!bus4.done) checkOutput("timeout_done4", 64'd0, 64'd1);
   endtask

   task automatic waitDrain(input int bound);
      int n = 0;
      while ((sb16.size() != 0 || sb4.size() != 0 || bus16.busy || bus16.done
              || bus4.busy || bus4.done) && n < bound) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain16", 64'(sb16.size()), 64'd0);
      checkOutput("drain4", 64'(sb4.size()), 64'd0);
   endtask

   initial begin
      int ia;
      int ib;
      compares          = 0;
      fails             = 0;
      rst               = 1'b1;
      bus16.start       = 1'b0;
      bus16.signed_mode = 1'b0;
      bus16.in0         = '0;
      bus16.in1         = '0;
      bus4.start        = 1'b0;
      bus4.signed_mode  = 1'b0;
      bus4.in0          = '0;
      bus4.in1          = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("idle_busy", 64'(bus16.busy), 64'd0);
         checkOutput("idle_done", 64'(bus16.done), 64'd0);
         checkOutput("idle_prod", 64'(bus16.final_prod), 64'd0);
      end

      $display("[TB] directed WIDTH=16 vectors");
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(VECS[i].sm, VECS[i].a, VECS[i].b, VECS[i].p);
         checkOutput("busy_run", 64'(bus16.busy), 64'd1);
         waitDone16(30);
         @(negedge clk);
      end

      $display("[TB] handshake: start during RUN is dropped, back-to-back from DONE");
      applyStimulus(1'b1, 16'd3, 16'd4, 32'd12);
      repeat (3) @(negedge clk);
      bus16.start = 1'b1;
      bus16.in0   = 16'd7;
      bus16.in1   = 16'd7;
      @(negedge clk);
      bus16.in0 = 16'd9;
      @(negedge clk);
      bus16.start = 1'b0;
      waitDone16(30);
      applyStimulus(1'b1, 16'd5, 16'd6, 32'd30);
      waitDone16(30);
      @(negedge clk);
      checkOutput("after_b2b_busy", 64'(bus16.busy), 64'd0);

      $display("[TB] reset mid-operation");
      bus16.start = 1'b1;
      bus16.in0   = 16'd100;
      bus16.in1   = 16'd100;
      @(negedge clk);
      bus16.start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", 64'(bus16.busy), 64'd0);
      checkOutput("abort_done", 64'(bus16.done), 64'd0);
      checkOutput("abort_prod", 64'(bus16.final_prod), 64'd0);
      repeat (25) @(negedge clk);
      checkOutput("abort_prod_hold", 64'(bus16.final_prod), 64'd0);

      rst         = 1'b1;
      bus16.start = 1'b1;
      @(negedge clk);
      rst         = 1'b0;
      bus16.start = 1'b0;
      checkOutput("rst_over_start_busy", 64'(bus16.busy), 64'd0);

      applyStimulus(1'b1, 16'd100, 16'd100, 32'h00002710);
      waitDone16(30);
      @(negedge clk);

      $display("[TB] exhaustive WIDTH=4 sweep");
      for (int sm = 0; sm < 2; sm++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               ia = (sm == 1 && a >= 8) ? a - 16 : a;
               ib = (sm == 1 && b >= 8) ? b - 16 : b;
               applyStimulus4(1'(sm), 4'(a), 4'(b), 8'(ia * ib));
               waitDone4(20);
            end
         end
      end

      waitDrain(60);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
